// File: rtl/ext_irq_ctrl_pkg.sv
// ext_irq_pkg: FSM state type, default sizes and the
// lowest-index priority encoder shared by the controller.
package ext_irq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } irq_state_t;

  localparam int N_IRQ_DEF       = 4;
  localparam int SYNC_STAGES_DEF = 2;

  function automatic logic [3:0] prio_enc(
    input logic [15:0] vec
  );
    prio_enc = '0;
    for (int i = 15; i >= 0; i--)
      if (vec[i]) prio_enc = 4'(i);
  endfunction

endpackage

// File: rtl/ext_irq_ctrl_if.sv
// ext_irq_ctrl_if: mask bus, ExtIRQ/ExtIAck/ERet handshake and status.
// slave = controller side, master = processor/software side.
interface ext_irq_ctrl_if #(
  parameter int N_IRQ = 4
);
  localparam int ID_W = $clog2(N_IRQ);

  logic             mask_we;
  logic [N_IRQ-1:0] mask_wdata;
  logic             ExtIAck;
  logic             ERet;
  logic             ExtIRQ;
  logic [ID_W-1:0]  irq_id;
  logic [N_IRQ-1:0] irq_pending;
  logic [N_IRQ-1:0] irq_mask;
  logic             in_service;

  modport master (
    output mask_we, mask_wdata, ExtIAck, ERet,
    input  ExtIRQ, irq_id, irq_pending,
    input  irq_mask, in_service
  );

  modport slave (
    input  mask_we, mask_wdata, ExtIAck, ERet,
    output ExtIRQ, irq_id, irq_pending,
    output irq_mask, in_service
  );

endinterface

// File: rtl/ext_irq_ctrl_sync.sv
// irq_sync: STAGES-deep flop chain per bit, async reset to 0.
// Ports: clk, reset, d (async in), q (synchronized out).
module irq_sync #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] chain [STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++)
        chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++)
        chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/ext_irq_ctrl.sv
// ext_irq_ctrl: sync, pend, mask and prioritise N_IRQ lines into ExtIRQ.
// Ports: clk, reset, irq_in, bus (slave). EXT_IRQ_LEVEL_EN = level lines.
module ext_irq_ctrl
  import ext_irq_pkg::*;
#(
  parameter int N_IRQ       = N_IRQ_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  ext_irq_ctrl_if.slave    bus
);

  localparam int ID_W = $clog2(N_IRQ);

  irq_state_t       state, state_n;
  logic [N_IRQ-1:0] s;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] mask;
  logic [N_IRQ-1:0] enabled;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  id, id_n;
  logic             ext_irq, ext_irq_n;
  logic             in_svc, in_svc_n;
  logic             ack;

  irq_sync #(
    .W      (N_IRQ),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (irq_in),
    .q     (s)
  );

  assign enabled = pending & mask;
  assign winner  = ID_W'(prio_enc(16'(enabled)));
  assign ack     = (state == REQ) && bus.ExtIAck;

`ifdef EXT_IRQ_LEVEL_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= s;
  end
`else
  logic [N_IRQ-1:0] s_d;
  logic [N_IRQ-1:0] clr;

  assign clr = ack ? (N_IRQ'(1) << id) : '0;

  // OR-ing the rise last lets a new edge beat the ack clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_d     <= '0;
      pending <= '0;
    end else begin
      s_d     <= s;
      pending <= (pending & ~clr) | (s & ~s_d);
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            mask <= '1;
    else if (bus.mask_we) mask <= bus.mask_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ext_irq <= 1'b0;
      id      <= '0;
      in_svc  <= 1'b0;
    end else begin
      state   <= state_n;
      ext_irq <= ext_irq_n;
      id      <= id_n;
      in_svc  <= in_svc_n;
    end
  end

  always_comb begin
    state_n   = state;
    ext_irq_n = ext_irq;
    id_n      = id;
    in_svc_n  = in_svc;
    unique case (state)
      IDLE: begin
        if (|enabled) begin
          state_n   = REQ;
          ext_irq_n = 1'b1;
          id_n      = winner;
        end
      end
      REQ: begin
        if (ack) begin
          state_n   = SERVICE;
          ext_irq_n = 1'b0;
          in_svc_n  = 1'b1;
        end
      end
      SERVICE: begin
        if (bus.ERet) begin
          state_n  = IDLE;
          in_svc_n = 1'b0;
        end
      end
      default: begin
        state_n   = IDLE;
        ext_irq_n = 1'b0;
        in_svc_n  = 1'b0;
      end
    endcase
  end

  assign bus.ExtIRQ      = ext_irq;
  assign bus.irq_id      = id;
  assign bus.irq_pending = pending;
  assign bus.irq_mask    = mask;
  assign bus.in_service  = in_svc;

endmodule
